// File: rtl/hydra_pkg.sv
// hydra_pkg -- shared constants and types for the 32-port round-robin arbiter.
//   PORT_NUM    : number of requesting ports
//   PORT_W      : width of a port index / rotating pointer
//   state_t     : arbiter state (IDLE = no grant, BUSY = one grant held)
//   onehot_idx  : one-hot grant vector to port index
package hydra_pkg;

    localparam int PORT_NUM = 32;
    localparam int PORT_W   = 5;
    localparam int HOLD_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index of the set bit; the input is one-hot or zero so OR-ing is exact.
    function automatic logic [PORT_W-1:0] onehot_idx(input logic [PORT_NUM-1:0] oh);
        logic [PORT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (oh[i]) idx = idx | PORT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_32_if.sv
// rr_arb_32_if -- request/grant bundle between requesters and the arbiter.
//   req       : per-port request (driven by master)
//   grant     : registered one-hot grant or zero (driven by slave)
//   grant_vld : high exactly when grant is non-zero
//   preempt   : one-cycle pulse after a hold-timeout revocation
interface rr_arb_32_if;
    import hydra_pkg::*;

    logic [PORT_NUM-1:0] req;
    logic [PORT_NUM-1:0] grant;
    logic                grant_vld;
    logic                preempt;

    modport master (output req, input grant, grant_vld, preempt);
    modport slave  (input req, output grant, grant_vld, preempt);

endinterface

// File: rtl/rr_pick_32.sv
// rr_pick_32 -- combinational rotating first-set-bit search.
//   req    : candidate request vector
//   ptr    : highest-priority port; order is ptr, ptr+1, ..., ptr-1 (mod 32)
//   mask   : ports excluded from this search
//   onehot : selected port, one-hot, or zero when no candidate remains
module rr_pick_32
    import hydra_pkg::*;
(
    input  logic [PORT_NUM-1:0] req,
    input  logic [PORT_W-1:0]   ptr,
    input  logic [PORT_NUM-1:0] mask,
    output logic [PORT_NUM-1:0] onehot
);

    logic [PORT_NUM-1:0]   cand;
    logic [2*PORT_NUM-1:0] dbl;
    logic [PORT_NUM-1:0]   rot;
    logic [PORT_NUM-1:0]   lsb;
    logic [2*PORT_NUM-1:0] back;

    always_comb begin
        cand   = req & ~mask;
        // Rotate right by ptr so the highest-priority port lands on bit 0.
        dbl    = {cand, cand};
        rot    = dbl[ptr +: PORT_NUM];
        // Isolate the lowest set bit of the rotated vector.
        lsb    = rot & (~rot + {{(PORT_NUM-1){1'b0}}, 1'b1});
        // Rotate left by ptr; the upper half holds the wrapped result.
        back   = {lsb, lsb} << ptr;
        onehot = back[2*PORT_NUM-1:PORT_NUM];
    end

endmodule

// File: rtl/rr_arb_32.sv
// rr_arb_32 -- 32-port round-robin arbiter with a bounded hold time.
//   clk       : clock, all state updates on its rising edge
//   rst       : asynchronous active-high reset
//   bus.req   : per-port request
//   bus.grant : registered one-hot grant (or zero)
//   bus.grant_vld : high exactly when grant is non-zero
//   bus.preempt   : one-cycle pulse aligned with the grant that follows a
//                   hold-timeout revocation
// MAX_HOLD (1..255) caps consecutive cycles of one grant. On any release the
// pointer moves past the holder and a new winner is chosen in the same cycle,
// so grants hand over back-to-back without an idle cycle.
module rr_arb_32
    import hydra_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arb_32_if.slave   bus
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    state_t              state,    state_n;
    logic [PORT_NUM-1:0] grant_q,  grant_n;
    logic                vld_q,    vld_n;
    logic                pre_q,    pre_n;
    logic [PORT_W-1:0]   ptr,      ptr_n;
    logic [HOLD_W-1:0]   cnt,      cnt_n;

    logic [PORT_W-1:0]   holder;
    logic                holder_req;
    logic                timeout;
    logic [PORT_W-1:0]   pick_ptr;
    logic [PORT_NUM-1:0] pick;

    assign holder     = onehot_idx(grant_q);
    assign holder_req = |(bus.req & grant_q);
    assign timeout    = (cnt == HOLD_LIM);

    // While busy, search starts just past the holder (the pointer it would
    // get on release); in IDLE grant_q is zero so the mask is a no-op.
    assign pick_ptr = (state == BUSY) ? holder + 5'd1 : ptr;

    rr_pick_32 u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .mask   (grant_q),
        .onehot (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            vld_q   <= 1'b0;
            pre_q   <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            vld_q   <= vld_n;
            pre_q   <= pre_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        pre_n   = 1'b0;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    grant_n = pick;
                    cnt_n   = 8'd1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (!holder_req || timeout) begin
                    ptr_n   = pick_ptr;
                    // Only a revocation of a still-requesting holder is a preemption.
                    pre_n   = holder_req && timeout;
                    grant_n = pick;
                    if (|pick) begin
                        cnt_n = 8'd1;
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                cnt_n   = '0;
            end
        endcase
        vld_n = |grant_n;
    end

    assign bus.grant     = grant_q;
    assign bus.grant_vld = vld_q;
    assign bus.preempt   = pre_q;

endmodule
